// File: rtl/apu_req_master_if.sv
// apu_req_master_if: core op port, APU req/rsp channel and writeback port bundle
interface apu_req_master_if #(
    parameter int NARGS    = 3,
    parameter int WOP      = 6,
    parameter int NDSFLAGS = 15,
    parameter int NUSFLAGS = 5,
    parameter int TAG_W    = 5
) ();
    logic                      op_valid_i;
    logic                      op_ready_o;
    logic [NARGS-1:0][31:0]    op_operands_i;
    logic [WOP-1:0]            op_op_i;
    logic [NDSFLAGS-1:0]       op_flags_i;
    logic [TAG_W-1:0]          op_waddr_i;
    logic                      apu_req_o;
    logic [NARGS-1:0][31:0]    apu_operands_o;
    logic [WOP-1:0]            apu_op_o;
    logic [NDSFLAGS-1:0]       apu_flags_o;
    logic                      apu_gnt_i;
    logic                      apu_rvalid_i;
    logic [31:0]               apu_result_i;
    logic [NUSFLAGS-1:0]       apu_flags_i;
    logic                      wb_valid_o;
    logic [TAG_W-1:0]          wb_waddr_o;
    logic [31:0]               wb_result_o;
    logic [NUSFLAGS-1:0]       wb_flags_o;
    logic                      busy_o;
    logic                      err_o;
    modport master (
        input  op_valid_i, op_operands_i, op_op_i, op_flags_i, op_waddr_i,
        input  apu_gnt_i, apu_rvalid_i, apu_result_i, apu_flags_i,
        output op_ready_o, apu_req_o, apu_operands_o, apu_op_o, apu_flags_o,
        output wb_valid_o, wb_waddr_o, wb_result_o, wb_flags_o, busy_o, err_o
    );
    modport slave (
        output op_valid_i, op_operands_i, op_op_i, op_flags_i, op_waddr_i,
        output apu_gnt_i, apu_rvalid_i, apu_result_i, apu_flags_i,
        input  op_ready_o, apu_req_o, apu_operands_o, apu_op_o, apu_flags_o,
        input  wb_valid_o, wb_waddr_o, wb_result_o, wb_flags_o, busy_o, err_o
    );
endinterface

// File: rtl/apu_req_master.sv
// apu_req_master: APU request initiator with in-order tag FIFO and writeback pulse
module apu_req_master #(
    parameter int NARGS           = 3,
    parameter int WOP             = 6,
    parameter int NDSFLAGS        = 15,
    parameter int NUSFLAGS        = 5,
    parameter int TAG_W           = 5,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic clk_i,
    input logic rst_i,
    apu_req_master_if.master bus
);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    typedef enum logic {IDLE, REQ} state_t;
    state_t                 r_state;
    logic [CW-1:0]          r_count;
    logic [PW-1:0]          r_wp, r_rp;
    logic [TAG_W-1:0]       r_fifo [MAX_OUTSTANDING];
    logic [NARGS-1:0][31:0] r_operands;
    logic [WOP-1:0]         r_op;
    logic [NDSFLAGS-1:0]    r_flags;
    logic [TAG_W-1:0]       r_waddr;
    logic                   r_wb_valid, r_err;
    logic [TAG_W-1:0]       r_wb_waddr;
    logic [31:0]            r_wb_result;
    logic [NUSFLAGS-1:0]    r_wb_flags;
    logic                   w_ready, w_push, w_pop;
    assign w_ready = (r_state == IDLE) && (r_count < CW'(MAX_OUTSTANDING));
    assign w_push  = (r_state == REQ) && bus.apu_gnt_i;
    assign w_pop   = bus.apu_rvalid_i && (r_count != '0);
    // Handshake outputs are forced low during reset so an in-flight request vanishes at once
    assign bus.op_ready_o     = !rst_i && w_ready;
    assign bus.apu_req_o      = !rst_i && (r_state == REQ);
    assign bus.busy_o         = !rst_i && ((r_state == REQ) || (r_count != '0));
    assign bus.apu_operands_o = r_operands;
    assign bus.apu_op_o       = r_op;
    assign bus.apu_flags_o    = r_flags;
    assign bus.wb_valid_o     = r_wb_valid;
    assign bus.wb_waddr_o     = r_wb_waddr;
    assign bus.wb_result_o    = r_wb_result;
    assign bus.wb_flags_o     = r_wb_flags;
    assign bus.err_o          = r_err;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_wp        <= '0;
            r_rp        <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) r_fifo[i] <= '0;
            r_operands  <= '0;
            r_op        <= '0;
            r_flags     <= '0;
            r_waddr     <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_waddr  <= '0;
            r_wb_result <= '0;
            r_wb_flags  <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_ready && bus.op_valid_i) begin
                r_operands <= bus.op_operands_i;
                r_op       <= bus.op_op_i;
                r_flags    <= bus.op_flags_i;
                r_waddr    <= bus.op_waddr_i;
                r_state    <= REQ;
            end
            if (w_push) begin
                r_fifo[r_wp] <= r_waddr;
                r_wp         <= (r_wp == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_wp + 1'b1;
                r_state      <= IDLE;
            end
            if (w_pop) begin
                r_wb_waddr  <= r_fifo[r_rp];
                r_wb_result <= bus.apu_result_i;
                r_wb_flags  <= bus.apu_flags_i;
                r_rp        <= (r_rp == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_rp + 1'b1;
            end
            r_wb_valid <= w_pop;
            r_err      <= r_err || (bus.apu_rvalid_i && (r_count == '0));
            r_count    <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: tb/tb_apu_req_master.sv
// tb_apu_req_master: scoreboard bench for the APU request master
module tb_apu_req_master;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    apu_req_master_if bus ();
    apu_req_master dut (.clk_i(clk), .rst_i(rst), .bus(bus.master));
    int n_cmp = 0, n_err = 0;
    logic [41:0] expq [$];
    logic [4:0]  tagq [$];
    logic        m_req = 0, m_err = 0;
    logic [4:0]  m_tag;
    logic [2:0][31:0] ops;
    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    always @(negedge clk) if (!rst && bus.wb_valid_o) begin
        if (expq.size() == 0) check("wb_unexpected", 1, 0);
        else begin
            logic [41:0] e;
            e = expq.pop_front();
            check("wb_waddr", bus.wb_waddr_o, e[41:37]);
            check("wb_result", bus.wb_result_o, e[36:5]);
            check("wb_flags", bus.wb_flags_o, e[4:0]);
        end
    end
    task automatic cyc(input logic g, input logic rv, input logic [31:0] res = 0, input logic [4:0] fl = 0);
        bus.apu_gnt_i = g;
        bus.apu_rvalid_i = rv;
        bus.apu_result_i = res;
        bus.apu_flags_i = fl;
        if (rv) begin
            if (tagq.size() != 0) expq.push_back({tagq.pop_front(), res, fl});
            else m_err = 1;
        end
        if (g && m_req) begin
            tagq.push_back(m_tag);
            m_req = 0;
        end
        @(negedge clk);
        bus.apu_gnt_i = 0;
        bus.apu_rvalid_i = 0;
        check("req", bus.apu_req_o, m_req);
        check("err", bus.err_o, m_err);
        check("busy", bus.busy_o, m_req || tagq.size() != 0);
    endtask
    task automatic send(input logic [4:0] tag, input logic [5:0] op, input logic [2:0][31:0] o);
        logic [14:0] fl;
        fl = 15'($urandom);
        bus.op_valid_i = 1;
        bus.op_operands_i = o;
        bus.op_op_i = op;
        bus.op_flags_i = fl;
        bus.op_waddr_i = tag;
        for (int k = 0; k < 20 && !bus.op_ready_o; k++) @(negedge clk);
        check("accept", bus.op_ready_o, 1);
        @(negedge clk);
        bus.op_valid_i = 0;
        m_req = 1;
        m_tag = tag;
        check("req_on", bus.apu_req_o, 1);
        check("ops", bus.apu_operands_o, o);
        check("op", bus.apu_op_o, op);
        check("dsflags", bus.apu_flags_o, fl);
        check("ready_in_req", bus.op_ready_o, 0);
    endtask
    function automatic logic [2:0][31:0] mk(input int a);
        logic [2:0][31:0] r;
        r[0] = a; r[1] = a * 3 + 1; r[2] = ~a;
        return r;
    endfunction
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
    initial begin
        bus.op_valid_i = 0; bus.op_operands_i = 0; bus.op_op_i = 0; bus.op_flags_i = 0;
        bus.op_waddr_i = 0; bus.apu_gnt_i = 0; bus.apu_rvalid_i = 0;
        bus.apu_result_i = 0; bus.apu_flags_i = 0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", bus.op_ready_o, 0);
        check("rst_req", bus.apu_req_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_err", bus.err_o, 0);
        check("rst_wb", bus.wb_valid_o, 0);
        rst = 0;
        @(negedge clk);
        check("idle_ready", bus.op_ready_o, 1);
        ops[0] = 1; ops[1] = 2; ops[2] = 3;
        send(7, 6'h01, ops);
        cyc(1, 0);
        cyc(0, 0);
        cyc(0, 1, 32'hDEADBEEF, 5'h1);
        cyc(0, 0);
        check("wb_hold", bus.wb_waddr_o, 7);
        send(9, 6'h2A, mk(9));
        bus.op_valid_i = 1; bus.op_op_i = 6'h3F; bus.op_operands_i = mk(99); bus.op_waddr_i = 1;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0);
            check("stall_ready", bus.op_ready_o, 0);
            check("stall_op", bus.apu_op_o, 6'h2A);
            check("stall_ops", bus.apu_operands_o, mk(9));
        end
        bus.op_valid_i = 0;
        cyc(1, 0);
        cyc(0, 1, 32'h1234_5678, 5'h1F);
        send(3, 6'h03, mk(3));
        cyc(1, 0);
        send(4, 6'h04, mk(4));
        cyc(1, 0);
        bus.op_valid_i = 1; bus.op_waddr_i = 5; bus.op_op_i = 6'h05; bus.op_operands_i = mk(5);
        cyc(0, 0);
        check("full_ready", bus.op_ready_o, 0);
        cyc(0, 0);
        check("full_ready2", bus.op_ready_o, 0);
        cyc(0, 1, 32'hA0A0_0003, 5'h3);
        check("ready_after_pop", bus.op_ready_o, 1);
        send(5, 6'h05, mk(5));
        cyc(1, 0);
        cyc(0, 1, 32'hA0A0_0004, 5'h4);
        cyc(0, 1, 32'hA0A0_0005, 5'h5);
        send(10, 6'h0A, mk(10));
        cyc(1, 0);
        send(11, 6'h0B, mk(11));
        cyc(1, 1, 32'hB0B0_000A, 5'hA);
        check("sim_ready", bus.op_ready_o, 1);
        cyc(0, 1, 32'hB0B0_000B, 5'hB);
        for (int i = 0; i < 6; i++) begin
            send(5'(12 + i), 6'(i), mk(12 + i));
            cyc(1, i > 0, 32'hC000_0000 + i, 5'(i));
        end
        cyc(0, 1, 32'hC0DE_0017, 5'h17);
        cyc(0, 1, 32'hBAD0_0000, 5'h0);
        cyc(0, 0);
        cyc(0, 0);
        send(20, 6'h14, mk(20));
        cyc(1, 1, 32'hBAD0_0001, 5'h2);
        cyc(0, 1, 32'hD000_0014, 5'h14);
        send(21, 6'h15, mk(21));
        cyc(1, 0);
        send(22, 6'h16, mk(22));
        rst = 1;
        #1;
        check("rst_req_async", bus.apu_req_o, 0);
        check("rst_busy_async", bus.busy_o, 0);
        tagq.delete(); expq.delete(); m_req = 0; m_err = 0;
        @(negedge clk);
        rst = 0;
        check("rst_err_clr", bus.err_o, 0);
        check("post_wb", bus.wb_valid_o, 0);
        @(negedge clk);
        check("post_ready", bus.op_ready_o, 1);
        check("post_busy", bus.busy_o, 0);
        cyc(0, 0);
        cyc(0, 0);
        check("sb_empty", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
